// File: rtl/idsadc_conv_ctrl_pkg.sv
// rtl/idsadc_conv_ctrl_pkg.sv - shared constants for the IDSADC conversion sequencer
package idsadc_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RST  = 2'd1;
    localparam logic [1:0] ST_CONV = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Byte offsets inside the 16-byte register window
    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_OSR    = 4'h4;
    localparam logic [3:0] REG_STATUS = 4'h8;
    localparam logic [3:0] REG_RESULT = 4'hC;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_ABORT  = 3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVERRUN = 2;

    localparam int OSR_MIN = 4;

endpackage

// File: rtl/idsadc_conv_ctrl_if.sv
// rtl/idsadc_conv_ctrl_if.sv - Wishbone slave bundle for the IDSADC sequencer
interface idsadc_conv_ctrl_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/idsadc_cic2_acc.sv
// rtl/idsadc_cic2_acc.sv - second-order sum-of-sums decimator accumulator
module idsadc_cic2_acc #(
    parameter int OSR_W = 16,
    parameter int RES_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [RES_W-1:0] acc2
);

    logic [OSR_W:0] acc1;
    logic [OSR_W:0] acc1_nxt;

    // acc2 integrates the already-updated acc1, giving sum_k (OSR-k)*bit_k
    assign acc1_nxt = acc1 + {{OSR_W{1'b0}}, bit_in};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc1 <= '0;
            acc2 <= '0;
        end else if (en) begin
            acc1 <= acc1_nxt;
            acc2 <= acc2 + {{(RES_W-OSR_W-1){1'b0}}, acc1_nxt};
        end
    end

endmodule

// File: rtl/idsadc_conv_ctrl.sv
// rtl/idsadc_conv_ctrl.sv - incremental delta-sigma ADC conversion sequencer with Wishbone registers
module idsadc_conv_ctrl
    import idsadc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          RST_CYCLES = 4,
    parameter int          OSR_W      = 16,
    parameter int          RES_W      = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    idsadc_conv_ctrl_if.slave wbs,
    input  logic              mod_bit_i,
    output logic              mod_en_o,
    output logic              int_rst_o,
    output logic              irq_o
);

    logic [1:0]       state;
    logic [OSR_W-1:0] cnt;
    logic [OSR_W-1:0] osr_q;
    logic [OSR_W-1:0] osr_raw;
    logic [OSR_W-1:0] osr_new;
    logic             cont_q;
    logic             irq_en_q;
    logic             start_q;
    logic             abort_q;
    logic             done_q;
    logic             ovr_q;
    logic [RES_W-1:0] result_q;
    logic [RES_W-1:0] acc2;
    logic             ack_q;
    logic [31:0]      rdat_q;
    logic [31:0]      rdata;
    logic [3:0]       ofs;
    logic             hit;
    logic             wr;
    logic             rd;
    logic             wr_ctrl;
    logic             wr_osr;
    logic             wr_stat;
    logic             busy;
    logic             done_set;
    logic             acc_clr;
    logic             unused_bus_bits;

    assign hit  = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q
                & (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wr   = hit & wbs.wbs_we_i;
    assign rd   = hit & ~wbs.wbs_we_i;
    assign ofs  = wbs.wbs_adr_i[3:0];
    assign busy = (state != ST_IDLE);

    assign wr_ctrl = wr & (ofs == REG_CTRL) & wbs.wbs_sel_i[0];
    assign wr_stat = wr & (ofs == REG_STATUS) & wbs.wbs_sel_i[0];
    assign wr_osr  = wr & (ofs == REG_OSR) & ~busy;

    assign unused_bus_bits = ^{wbs.wbs_dat_i, wbs.wbs_sel_i};

    for (genvar i = 0; i < OSR_W; i++) begin : g_osr_merge
        assign osr_raw[i] = wbs.wbs_sel_i[i/8] ? wbs.wbs_dat_i[i] : osr_q[i];
    end

    assign osr_new = (osr_raw < OSR_W'(OSR_MIN)) ? OSR_W'(OSR_MIN) : osr_raw;

    assign mod_en_o  = (state == ST_CONV);
    assign int_rst_o = (state == ST_RST);
    assign irq_o     = done_q & irq_en_q;

    // An abort in the DONE cycle leaves RESULT and the sticky flags untouched
    assign done_set = (state == ST_DONE) & ~abort_q;
    assign acc_clr  = ~abort_q & (((state == ST_IDLE) & start_q)
                                | ((state == ST_DONE) & cont_q));

    always_comb begin
        rdata = '0;
        case (ofs)
            REG_CTRL: begin
                rdata[CTRL_CONT]   = cont_q;
                rdata[CTRL_IRQ_EN] = irq_en_q;
            end
            REG_OSR:    rdata[OSR_W-1:0] = osr_q;
            REG_STATUS: begin
                rdata[STAT_BUSY]    = busy;
                rdata[STAT_DONE]    = done_q;
                rdata[STAT_OVERRUN] = ovr_q;
            end
            REG_RESULT: rdata[RES_W-1:0] = result_q;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q  <= 1'b0;
            rdat_q <= '0;
        end else begin
            ack_q  <= hit;
            rdat_q <= rd ? rdata : '0;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = rdat_q;

    // start/abort are one-cycle pulses visible in the ack cycle
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            cont_q   <= 1'b0;
            irq_en_q <= 1'b0;
            osr_q    <= OSR_W'(16);
        end else begin
            start_q <= wr_ctrl & wbs.wbs_dat_i[CTRL_START];
            abort_q <= wr_ctrl & wbs.wbs_dat_i[CTRL_ABORT];
            if (wr_ctrl) begin
                cont_q   <= wbs.wbs_dat_i[CTRL_CONT];
                irq_en_q <= wbs.wbs_dat_i[CTRL_IRQ_EN];
            end
            if (wr_osr) begin
                osr_q <= osr_new;
            end
        end
    end

    // Hardware set beats a same-cycle W1C
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= done_set | (done_q & ~(wr_stat & wbs.wbs_dat_i[STAT_DONE]));
            ovr_q  <= (done_set & done_q)
                    | (ovr_q & ~(wr_stat & wbs.wbs_dat_i[STAT_OVERRUN]));
            if (done_set) begin
                result_q <= acc2;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (abort_q) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_q) begin
                        state <= ST_RST;
                        cnt   <= '0;
                    end
                end
                ST_RST: begin
                    if (cnt == OSR_W'(RST_CYCLES - 1)) begin
                        state <= ST_CONV;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + OSR_W'(1);
                    end
                end
                ST_CONV: begin
                    if (cnt == osr_q - OSR_W'(1)) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + OSR_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= cont_q ? ST_RST : ST_IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    idsadc_cic2_acc #(
        .OSR_W (OSR_W),
        .RES_W (RES_W)
    ) u_acc (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (acc_clr),
        .en     (mod_en_o),
        .bit_in (mod_bit_i),
        .acc2   (acc2)
    );

endmodule
